multi_phase_signal_ctrl: RTL and testbench



---
 rtl/multi_phase_signal_ctrl.sv | 127 ++++++++++++
 tb/tb_multi_phase_signal_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/multi_phase_signal_ctrl.sv
// Round-robin intersection controller: NUM_PHASES vehicle heads plus one pedestrian walk phase.
// One sequencing FSM; every output is registered from the next-state decision.
module multi_phase_signal_ctrl #(
   parameter int NUM_PHASES   = 4,
   parameter int GREEN_MIN    = 4,
   parameter int GREEN_MAX    = 10,
   parameter int YELLOW_TIME  = 2,
   parameter int ALL_RED_TIME = 1,
   parameter int WALK_TIME    = 3,
   parameter int TIMER_W      = 8
) (
   input  logic                                                 clk,
   input  logic                                                 rst,
   input  logic [NUM_PHASES-1:0]                                car_req,
   input  logic                                                 ped_req,
   output logic [2*NUM_PHASES-1:0]                              light,
   output logic                                                 walk_signal,
   output logic [(NUM_PHASES > 1 ? $clog2(NUM_PHASES) : 1)-1:0] active_phase,
   output logic                                                 ped_pending
);

   localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

   localparam logic [TIMER_W-1:0] GMIN_END = TIMER_W'(GREEN_MIN - 1);
   localparam logic [TIMER_W-1:0] GMAX_END = TIMER_W'(GREEN_MAX - 1);
   localparam logic [TIMER_W-1:0] YEL_END  = TIMER_W'(YELLOW_TIME - 1);
   localparam logic [TIMER_W-1:0] RED_END  = TIMER_W'(ALL_RED_TIME - 1);
   localparam logic [TIMER_W-1:0] WALK_END = TIMER_W'(WALK_TIME - 1);

   typedef enum logic [2:0] {IDLE, GREEN, YELLOW, ALL_RED, WALK} state_t;

   state_t                  state, nxt;
   logic [TIMER_W-1:0]      cnt;
   logic [PW-1:0]           last, grant, nxt_phase;
   logic                    from_walk;
   logic [NUM_PHASES-1:0]   others;
   logic                    any_req, other_req, own_req, found;
   logic [2*NUM_PHASES-1:0] nxt_light;
   int                      idx;

   // Scan last+1, last+2, ... wrapping back to last itself.
   always_comb begin
      grant = last;
      found = 1'b0;
      idx   = 0;
      for (int i = 1; i <= NUM_PHASES; i++) begin
         idx = int'(last) + i;
         if (idx >= NUM_PHASES) idx = idx - NUM_PHASES;
         if (!found && car_req[idx[PW-1:0]]) begin
            grant = PW'(idx);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      others               = car_req;
      others[active_phase] = 1'b0;
   end

   assign any_req   = |car_req;
   assign other_req = |others;
   assign own_req   = car_req[active_phase];

   always_comb begin
      nxt = state;
      case (state)
         IDLE: begin
            if (ped_pending)  nxt = WALK;
            else if (any_req) nxt = GREEN;
         end
         GREEN: begin
            if (cnt == GMAX_END) nxt = YELLOW;
            else if (cnt >= GMIN_END && (other_req || ped_pending || !own_req)) nxt = YELLOW;
         end
         YELLOW:  if (cnt == YEL_END) nxt = ALL_RED;
         ALL_RED: begin
            if (cnt == RED_END) begin
               if (ped_pending && !from_walk) nxt = WALK;
               else if (any_req)              nxt = GREEN;
               else                           nxt = IDLE;
            end
         end
         WALK:    if (cnt == WALK_END) nxt = ALL_RED;
         default: nxt = IDLE;
      endcase
   end

   // Head pattern for the state about to be entered, so light is a plain register.
   always_comb begin
      nxt_light = '0;
      nxt_phase = (nxt == GREEN && state != GREEN) ? grant : active_phase;
      if (nxt == GREEN)       nxt_light[2*int'(nxt_phase) +: 2] = 2'b01;
      else if (nxt == YELLOW) nxt_light[2*int'(nxt_phase) +: 2] = 2'b10;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         last         <= PW'(NUM_PHASES - 1);
         active_phase <= '0;
         from_walk    <= 1'b0;
         ped_pending  <= 1'b0;
         light        <= '0;
         walk_signal  <= 1'b0;
      end else begin
         if (nxt != state) begin
            state     <= nxt;
            cnt       <= '0;
            from_walk <= (state == WALK);
            if (nxt == GREEN) begin
               last         <= grant;
               active_phase <= grant;
            end
         end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
         end
         // WALK entry clears the latch even if the button is pressed on that edge.
         if (nxt == WALK && state != WALK)  ped_pending <= 1'b0;
         else if (ped_req && state != WALK) ped_pending <= 1'b1;
         light       <= nxt_light;
         walk_signal <= (nxt == WALK);
      end
   end

endmodule

// File: tb/tb_multi_phase_signal_ctrl.sv
// Directed bench for multi_phase_signal_ctrl with default parameters.
module tb_multi_phase_signal_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] car_req = '0;
   logic       ped_req = 1'b0;
   logic [7:0] light;
   logic       walk_signal;
   logic [1:0] active_phase;
   logic       ped_pending;

   int checks = 0;
   int errors = 0;

   multi_phase_signal_ctrl dut (
      .clk(clk), .rst(rst), .car_req(car_req), .ped_req(ped_req),
      .light(light), .walk_signal(walk_signal),
      .active_phase(active_phase), .ped_pending(ped_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // n cycles with a fixed expected light / walk / pending pattern
   task automatic seq(input string tag, input int n, input logic [7:0] l,
                      input logic w, input logic p);
      for (int i = 0; i < n; i++) begin
         step();
         chk({tag, " light"}, 32'(light), 32'(l));
         chk({tag, " walk"},  32'(walk_signal), 32'(w));
         chk({tag, " ped"},   32'(ped_pending), 32'(p));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; car_req = '0; ped_req = 1'b0;
      step();
      chk("rst light", 32'(light), 32'h0);
      chk("rst walk",  32'(walk_signal), 32'h0);
      chk("rst ped",   32'(ped_pending), 32'h0);
      chk("rst phase", 32'(active_phase), 32'h0);
      rst = 1'b0;
   endtask

   initial begin
      // 1: single requester maxes out and is re-granted
      do_reset();
      car_req = 4'b0100;
      seq("t1 green", 10, 8'h10, 1'b0, 1'b0);
      chk("t1 phase", 32'(active_phase), 32'd2);
      seq("t1 yellow", 2, 8'h20, 1'b0, 1'b0);
      seq("t1 allred", 1, 8'h00, 1'b0, 1'b0);
      seq("t1 regreen", 1, 8'h10, 1'b0, 1'b0);

      // 2: two requesters alternate, each gapping out at minimum
      do_reset();
      car_req = 4'b1010;
      seq("t2 g1", 4, 8'h04, 1'b0, 1'b0);
      chk("t2 phase1", 32'(active_phase), 32'd1);
      seq("t2 y1", 2, 8'h08, 1'b0, 1'b0);
      seq("t2 r1", 1, 8'h00, 1'b0, 1'b0);
      seq("t2 g3", 4, 8'h40, 1'b0, 1'b0);
      chk("t2 phase3", 32'(active_phase), 32'd3);
      seq("t2 y3", 2, 8'h80, 1'b0, 1'b0);
      seq("t2 r3", 1, 8'h00, 1'b0, 1'b0);
      seq("t2 g1 again", 1, 8'h04, 1'b0, 1'b0);

      // 3: one-cycle request gives exactly minimum green then IDLE
      do_reset();
      car_req = 4'b0001;
      seq("t3 g0 first", 1, 8'h01, 1'b0, 1'b0);
      car_req = 4'b0000;
      seq("t3 g0", 3, 8'h01, 1'b0, 1'b0);
      seq("t3 y0", 2, 8'h02, 1'b0, 1'b0);
      seq("t3 r0", 1, 8'h00, 1'b0, 1'b0);
      seq("t3 idle", 3, 8'h00, 1'b0, 1'b0);
      chk("t3 phase", 32'(active_phase), 32'd0);

      // 4: pedestrian press during green pre-empts the next grant
      do_reset();
      car_req = 4'b0011;
      seq("t4 g0 c0", 1, 8'h01, 1'b0, 1'b0);
      ped_req = 1'b1;
      seq("t4 g0 c1", 1, 8'h01, 1'b0, 1'b1);
      ped_req = 1'b0;
      seq("t4 g0", 2, 8'h01, 1'b0, 1'b1);
      seq("t4 y0", 2, 8'h02, 1'b0, 1'b1);
      seq("t4 r0", 1, 8'h00, 1'b0, 1'b1);
      seq("t4 walk", 3, 8'h00, 1'b1, 1'b0);
      seq("t4 rw", 1, 8'h00, 1'b0, 1'b0);
      seq("t4 g1", 1, 8'h04, 1'b0, 1'b0);
      chk("t4 phase", 32'(active_phase), 32'd1);

      // 5: press on the IDLE decision edge latches but does not redirect it;
      //    button held through WALK is ignored
      do_reset();
      car_req = 4'b0001;
      ped_req = 1'b1;
      seq("t5 g0 c0", 1, 8'h01, 1'b0, 1'b1);
      ped_req = 1'b0;
      seq("t5 g0", 3, 8'h01, 1'b0, 1'b1);
      seq("t5 y0", 2, 8'h02, 1'b0, 1'b1);
      seq("t5 r0", 1, 8'h00, 1'b0, 1'b1);
      ped_req = 1'b1;
      seq("t5 walk", 3, 8'h00, 1'b1, 1'b0);
      seq("t5 rw", 1, 8'h00, 1'b0, 1'b0);
      ped_req = 1'b0;
      seq("t5 g0 again", 1, 8'h01, 1'b0, 1'b0);

      // 6: asynchronous reset during yellow, then restart
      do_reset();
      car_req = 4'b0100;
      ped_req = 1'b1;
      seq("t6 g2 c0", 1, 8'h10, 1'b0, 1'b1);
      ped_req = 1'b0;
      seq("t6 g2", 3, 8'h10, 1'b0, 1'b1);
      seq("t6 y2", 1, 8'h20, 1'b0, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("t6 async light", 32'(light), 32'h0);
      chk("t6 async walk",  32'(walk_signal), 32'h0);
      chk("t6 async ped",   32'(ped_pending), 32'h0);
      chk("t6 async phase", 32'(active_phase), 32'd0);
      step();
      chk("t6 held light", 32'(light), 32'h0);
      rst = 1'b0;
      seq("t6 restart g2", 1, 8'h10, 1'b0, 1'b0);
      chk("t6 phase", 32'(active_phase), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
